// File: rtl/snake_object_gen_if.sv
// Snake game-state bus: control/pixel requests in,
// object class and game status out.
interface snake_object_gen_if;
  logic       Start;
  logic       Move_tick;
  logic [1:0] Dir;
  logic       Grow;
  logic [9:0] Pixel_x;
  logic [9:0] Pixel_y;
  logic [1:0] Object;
  logic [5:0] Head_x;
  logic [4:0] Head_y;
  logic [5:0] Length;
  logic       Game_over;

  modport master (
    output Start, Move_tick, Dir, Grow,
    output Pixel_x, Pixel_y,
    input  Object, Head_x, Head_y,
    input  Length, Game_over
  );

  modport slave (
    input  Start, Move_tick, Dir, Grow,
    input  Pixel_x, Pixel_y,
    output Object, Head_x, Head_y,
    output Length, Game_over
  );
endinterface

// File: rtl/snake_object_gen.sv
// Snake game state on a cell grid plus per-pixel
// object classification for the VGA stage.
module snake_object_gen #(
  parameter int MAX_LEN  = 16,
  parameter int INIT_LEN = 3,
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30
) (
  input  logic Clk_25mhz,
  input  logic Rst,
  snake_object_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DEAD
  } state_t;

  state_t     state_q, state_n;
  logic [5:0] seg_x [MAX_LEN];
  logic [4:0] seg_y [MAX_LEN];
  logic [5:0] len_q;
  logic [1:0] dir_q;
  logic       gp_q;
  logic [1:0] obj_q, obj_n;

  logic [1:0] nd;
  logic [5:0] cx;
  logic [4:0] cy;
  logic       rev, wall, self_hit;
  logic       grow_eff, move_ok;

  logic [5:0] px;
  logic [5:0] py;
  logic       vis, h_hit, b_hit, w_hit;

  // Game state register
  always_ff @(posedge Clk_25mhz or posedge Rst) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_n;
  end

  // Candidate head, collisions and next state
  always_comb begin
    state_n  = state_q;
    move_ok  = 1'b0;
    self_hit = 1'b0;
    rev = (bus.Dir[1] == dir_q[1]) &&
          (bus.Dir[0] != dir_q[0]);
    nd  = rev ? dir_q : bus.Dir;
    cx  = seg_x[0];
    cy  = seg_y[0];
    case (nd)
      2'b00:   cy = seg_y[0] - 5'd1;
      2'b01:   cy = seg_y[0] + 5'd1;
      2'b10:   cx = seg_x[0] - 6'd1;
      default: cx = seg_x[0] + 6'd1;
    endcase
    wall = (cx == 6'd0) ||
           (cx == 6'(GRID_W - 1)) ||
           (cy == 5'd0) ||
           (cy == 5'(GRID_H - 1));
    grow_eff = (gp_q | bus.Grow) &&
               (len_q < 6'(MAX_LEN));
    // Tail cell is vacated unless we grow
    for (int k = 1; k < MAX_LEN; k++) begin
      if (((k + 2 <= int'(len_q)) ||
           (grow_eff && (k + 1 == int'(len_q)))) &&
          seg_x[k] == cx && seg_y[k] == cy)
        self_hit = 1'b1;
    end
    case (state_q)
      S_IDLE: if (bus.Start) state_n = S_RUN;
      S_RUN: begin
        if (bus.Move_tick) begin
          if (wall || self_hit) state_n = S_DEAD;
          else                  move_ok = 1'b1;
        end
      end
      default: state_n = state_q;
    endcase
  end

  // Segments, length, direction and pending grow
  always_ff @(posedge Clk_25mhz or posedge Rst) begin
    if (Rst) begin
      for (int k = 0; k < MAX_LEN; k++) begin
        if (k < INIT_LEN) begin
          seg_x[k] <= 6'(20 - k);
          seg_y[k] <= 5'd15;
        end else begin
          seg_x[k] <= '0;
          seg_y[k] <= '0;
        end
      end
      len_q <= 6'(INIT_LEN);
      dir_q <= 2'b11;
      gp_q  <= 1'b0;
    end else begin
      if (state_q == S_RUN) begin
        if (bus.Move_tick) gp_q <= 1'b0;
        else if (bus.Grow) gp_q <= 1'b1;
      end
      if (move_ok) begin
        for (int k = MAX_LEN - 1; k > 0; k--) begin
          seg_x[k] <= seg_x[k-1];
          seg_y[k] <= seg_y[k-1];
        end
        seg_x[0] <= cx;
        seg_y[0] <= cy;
        dir_q    <= nd;
        if (grow_eff) len_q <= len_q + 6'd1;
      end
    end
  end

  // Pixel cell classification
  always_comb begin
    px    = bus.Pixel_x[9:4];
    py    = bus.Pixel_y[9:4];
    vis   = (bus.Pixel_x < 10'd640) &&
            (bus.Pixel_y < 10'd480);
    h_hit = (seg_x[0] == px) &&
            ({1'b0, seg_y[0]} == py);
    b_hit = 1'b0;
    for (int k = 1; k < MAX_LEN; k++) begin
      if ((k < int'(len_q)) &&
          seg_x[k] == px &&
          {1'b0, seg_y[k]} == py)
        b_hit = 1'b1;
    end
    w_hit = (px == 6'd0) ||
            (px == 6'(GRID_W - 1)) ||
            (py == 6'd0) ||
            (py == 6'(GRID_H - 1));
    obj_n = 2'b00;
    if (vis) begin
      if (h_hit)      obj_n = 2'b01;
      else if (b_hit) obj_n = 2'b10;
      else if (w_hit) obj_n = 2'b11;
    end
  end

  // Object register, one cycle behind the pixel
  always_ff @(posedge Clk_25mhz or posedge Rst) begin
    if (Rst) obj_q <= 2'b00;
    else     obj_q <= obj_n;
  end

  assign bus.Object    = obj_q;
  assign bus.Head_x    = seg_x[0];
  assign bus.Head_y    = seg_y[0];
  assign bus.Length    = len_q;
  assign bus.Game_over = (state_q == S_DEAD);

endmodule

// File: tb/tb_snake_object_gen.sv
// Directed + random bench for snake_object_gen
// against a queue-based game model.
module tb_snake_object_gen;

  localparam int MAXL = 16;

  logic Clk_25mhz = 1'b0;
  logic Rst = 1'b1;

  snake_object_gen_if bus ();

  snake_object_gen dut (
    .Clk_25mhz (Clk_25mhz),
    .Rst       (Rst),
    .bus       (bus)
  );

  always #5 Clk_25mhz = ~Clk_25mhz;

  int n_vec = 0;
  int n_err = 0;

  int qx[$];
  int qy[$];
  int m_len, m_dir, m_state, m_gp, m_obj;

  function automatic int obj_of(int px, int py);
    int cx, cy;
    if (px >= 640 || py >= 480) return 0;
    cx = px / 16;
    cy = py / 16;
    if (qx[0] == cx && qy[0] == cy) return 1;
    for (int i = 1; i < qx.size(); i++)
      if (qx[i] == cx && qy[i] == cy) return 2;
    if (cx == 0 || cx == 39 || cy == 0 || cy == 29)
      return 3;
    return 0;
  endfunction

  task automatic model_reset();
    qx = {};
    qy = {};
    for (int k = 0; k < 3; k++) begin
      qx.push_back(20 - k);
      qy.push_back(15);
    end
    m_len = 3;
    m_dir = 3;
    m_state = 0;
    m_gp = 0;
    m_obj = 0;
  endtask

  task automatic model_step(
    int st, int mt, int d, int gr, int px, int py
  );
    int nobj, nd, hx, hy, keep;
    bit growing, hit;
    nobj = obj_of(px, py);
    if (m_state == 0) begin
      if (st != 0) m_state = 1;
    end else if (m_state == 1) begin
      if (mt != 0) begin
        nd = ((d ^ m_dir) == 1) ? m_dir : d;
        hx = qx[0];
        hy = qy[0];
        if (nd == 0) hy--;
        else if (nd == 1) hy++;
        else if (nd == 2) hx--;
        else hx++;
        growing = (m_gp != 0 || gr != 0) &&
                  m_len < MAXL;
        hit = hx == 0 || hx == 39 ||
              hy == 0 || hy == 29;
        keep = growing ? m_len : m_len - 1;
        for (int i = 0; i < keep; i++)
          if (qx[i] == hx && qy[i] == hy) hit = 1;
        if (hit) m_state = 2;
        else begin
          qx.push_front(hx);
          qy.push_front(hy);
          m_dir = nd;
          if (growing) m_len++;
          while (qx.size() > m_len) begin
            void'(qx.pop_back());
            void'(qy.pop_back());
          end
        end
        m_gp = 0;
      end else if (gr != 0) m_gp = 1;
    end
    m_obj = nobj;
  endtask

  task automatic chk(
    string tag, logic [31:0] got, logic [31:0] exp
  );
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("object", 32'(bus.Object), m_obj);
    chk("head_x", 32'(bus.Head_x), qx[0]);
    chk("head_y", 32'(bus.Head_y), qy[0]);
    chk("length", 32'(bus.Length), m_len);
    chk("game_over", 32'(bus.Game_over),
        (m_state == 2) ? 1 : 0);
  endtask

  task automatic step(
    int st, int mt, int d, int gr, int px, int py
  );
    bus.Start     = st[0];
    bus.Move_tick = mt[0];
    bus.Dir       = d[1:0];
    bus.Grow      = gr[0];
    bus.Pixel_x   = px[9:0];
    bus.Pixel_y   = py[9:0];
    @(posedge Clk_25mhz);
    model_step(st, mt, d, gr, px, py);
    #1;
    check_all();
  endtask

  task automatic mv(int d);
    step(0, 1, d, 0, 0, 0);
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    bus.Start = 0;
    bus.Move_tick = 0;
    bus.Grow = 0;
    bus.Dir = 2'b11;
    #1;
    model_reset();
    check_all();
    @(posedge Clk_25mhz);
    #1;
    Rst = 1'b0;
  endtask

  initial begin
    bus.Start = 0;
    bus.Move_tick = 0;
    bus.Dir = 2'b11;
    bus.Grow = 0;
    bus.Pixel_x = 0;
    bus.Pixel_y = 0;
    model_reset();
    repeat (2) @(posedge Clk_25mhz);
    #1;
    Rst = 1'b0;

    // reset mid-run, then move without Start
    step(1, 0, 3, 0, 0, 0);
    mv(3);
    mv(0);
    do_reset();
    chk("rst_hx", 32'(bus.Head_x), 20);
    chk("rst_len", 32'(bus.Length), 3);
    mv(3);
    chk("idle_hx", 32'(bus.Head_x), 20);

    // three right moves, then reverse ignored
    step(1, 0, 3, 0, 0, 0);
    repeat (3) mv(3);
    chk("r3_hx", 32'(bus.Head_x), 23);
    step(0, 0, 3, 0, 352, 240);
    chk("r3_body", 32'(bus.Object), 2);
    mv(2);
    chk("rev_hx", 32'(bus.Head_x), 24);

    // pixel sweep after reset
    do_reset();
    step(0, 0, 3, 0, 320, 240);
    chk("sw_head", 32'(bus.Object), 1);
    step(0, 0, 3, 0, 304, 240);
    chk("sw_body", 32'(bus.Object), 2);
    step(0, 0, 3, 0, 0, 0);
    chk("sw_wall", 32'(bus.Object), 3);
    step(0, 0, 3, 0, 100, 100);
    step(0, 0, 3, 0, 700, 240);
    chk("sw_off", 32'(bus.Object), 0);
    step(0, 0, 3, 0, 639, 479);

    // wall hit
    do_reset();
    step(1, 0, 3, 0, 0, 0);
    repeat (18) mv(3);
    chk("w18_hx", 32'(bus.Head_x), 38);
    mv(3);
    chk("w19_go", 32'(bus.Game_over), 1);
    chk("w19_hx", 32'(bus.Head_x), 38);
    mv(0);
    step(1, 1, 1, 1, 600, 240);
    step(0, 0, 1, 0, 608, 240);

    // growth and saturation
    do_reset();
    step(1, 0, 3, 0, 0, 0);
    step(0, 0, 3, 1, 0, 0);
    mv(3);
    chk("g_len4", 32'(bus.Length), 4);
    step(0, 0, 3, 0, 288, 240);
    chk("g_tail", 32'(bus.Object), 2);
    step(0, 1, 3, 1, 0, 0);
    chk("g_len5", 32'(bus.Length), 5);
    repeat (13) step(0, 1, 3, 1, 0, 0);
    chk("g_sat", 32'(bus.Length), 16);
    mv(3);
    chk("g_sat2", 32'(bus.Length), 16);

    // self hit
    do_reset();
    step(1, 0, 3, 0, 0, 0);
    step(0, 1, 3, 1, 0, 0);
    step(0, 1, 3, 1, 0, 0);
    mv(0);
    mv(2);
    chk("s_go0", 32'(bus.Game_over), 0);
    mv(1);
    chk("s_go1", 32'(bus.Game_over), 1);
    chk("s_hx", 32'(bus.Head_x), 21);
    chk("s_hy", 32'(bus.Head_y), 14);
    mv(3);

    // random play
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      int st, mt, d, gr, px, py;
      if (m_state == 2 && $urandom_range(0, 7) == 0)
        do_reset();
      st = ($urandom_range(0, 15) == 0) ? 1 : 0;
      mt = ($urandom_range(0, 3) == 0) ? 1 : 0;
      d  = $urandom_range(0, 3);
      gr = ($urandom_range(0, 5) == 0) ? 1 : 0;
      if ($urandom_range(0, 1) == 0) begin
        px = qx[0] * 16 + $urandom_range(0, 63) - 24;
        py = qy[0] * 16 + $urandom_range(0, 63) - 24;
        if (px < 0) px = 0;
        if (py < 0) py = 0;
      end else begin
        px = $urandom_range(0, 700);
        py = $urandom_range(0, 520);
      end
      step(st, mt, d, gr, px, py);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
